rr_select_arbiter: RTL and testbench

Round-robin arbiter that shares one decoded select resource between NUM_OUTPUT requesters. It issues a registered binary grant address (drives the address decoder's in_address) plus a matching one-hot grant and a valid flag. Grants are held until the owner signals done, drops its request, or a hold timeout fires. A mandatory one-cycle dead gap between owners guarantees no two selects ever overlap.

---
 rtl/rr_select_arbiter_pkg.sv | 15 +
 rtl/rr_select_arbiter_if.sv | 29 ++
 rtl/rr_priority_pick.sv | 38 +++
 rtl/rr_select_arbiter.sv | 117 +++++++++++
 tb/tb_rr_select_arbiter.sv | 133 +++++++++++++
 5 files changed

// File: rtl/rr_select_arbiter_pkg.sv
// rtl/rr_select_arbiter_pkg.sv - shared state encoding and width helper for the select arbiter
package rr_select_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Address width for the decoded select index; at least one bit.
    function automatic int addr_width(input int num_output);
        return (num_output < 2) ? 1 : $clog2(num_output);
    endfunction

endpackage

// File: rtl/rr_select_arbiter_if.sv
// rtl/rr_select_arbiter_if.sv - request/grant bundle between requesters and the select arbiter
interface rr_select_arbiter_if
    import rr_select_arbiter_pkg::*;
#(
    parameter int NUM_OUTPUT = 4
);
    localparam int AW = addr_width(NUM_OUTPUT);

    logic [NUM_OUTPUT-1:0] in_request;
    logic                  in_done;
    logic [AW-1:0]         out_address;
    logic [NUM_OUTPUT-1:0] out_grant;
    logic                  out_valid;
    logic                  out_timeout;
    logic                  out_error;

    // Requester side drives requests/done and observes the grant.
    modport master (
        output in_request, in_done,
        input  out_address, out_grant, out_valid, out_timeout, out_error
    );

    // Arbiter side.
    modport slave (
        input  in_request, in_done,
        output out_address, out_grant, out_valid, out_timeout, out_error
    );

endinterface

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational rotating-priority search starting after last_owner
module rr_priority_pick
    import rr_select_arbiter_pkg::*;
#(
    parameter int NUM_OUTPUT = 4,
    parameter int AW         = addr_width(NUM_OUTPUT)
) (
    input  logic [NUM_OUTPUT-1:0] req,
    input  logic [AW-1:0]         last_owner,
    output logic [AW-1:0]         winner,
    output logic                  any_req
);

    logic [AW:0]   sum;
    logic [AW-1:0] idx;

    // Walk candidates from farthest to nearest so the nearest set bit after
    // last_owner overwrites the others; modulo is done by one conditional
    // subtract so non-power-of-two counts wrap correctly.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int i = NUM_OUTPUT; i >= 1; i--) begin
            sum = {1'b0, last_owner} + (AW+1)'(i);
            if (sum >= (AW+1)'(NUM_OUTPUT)) begin
                sum = sum - (AW+1)'(NUM_OUTPUT);
            end
            idx = sum[AW-1:0];
            if (req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_select_arbiter.sv
// rtl/rr_select_arbiter.sv - round-robin owner of a decoded select with hold limit and dead gap
module rr_select_arbiter
    import rr_select_arbiter_pkg::*;
#(
    parameter int NUM_OUTPUT = 4,
    parameter int MAX_HOLD   = 16
) (
    input  logic               clk,
    input  logic               rst,
    rr_select_arbiter_if.slave bus
);

    localparam int AW = addr_width(NUM_OUTPUT);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [AW-1:0] LAST_RST  = AW'(NUM_OUTPUT - 1);

    state_e                state_q, state_d;
    logic [AW-1:0]         address_q, address_d;
    logic [NUM_OUTPUT-1:0] grant_q, grant_d;
    logic                  valid_q, valid_d;
    logic                  timeout_q, timeout_d;
    logic                  error_q, error_d;
    logic [HW-1:0]         hold_q, hold_d;
    logic [AW-1:0]         last_q, last_d;

    logic [AW-1:0] winner;
    logic          any_req;
    logic          owner_req;
    logic          hold_expired;

    rr_priority_pick #(
        .NUM_OUTPUT (NUM_OUTPUT),
        .AW         (AW)
    ) u_pick (
        .req        (bus.in_request),
        .last_owner (last_q),
        .winner     (winner),
        .any_req    (any_req)
    );

    assign owner_req    = bus.in_request[address_q];
    assign hold_expired = (hold_q == HOLD_LAST);

    // Next-state and registered-output computation for IDLE/GRANT/GAP.
    always_comb begin
        state_d   = state_q;
        address_d = address_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        hold_d    = hold_q;
        last_d    = last_q;
        timeout_d = 1'b0;
        // done without an owner is flagged but never changes arbitration
        error_d   = bus.in_done & ~valid_q;

        unique case (state_q)
            ST_GRANT: begin
                if (bus.in_done || !owner_req || hold_expired) begin
                    state_d   = ST_GAP;
                    valid_d   = 1'b0;
                    grant_d   = '0;
                    hold_d    = '0;
                    // timeout only when the counter alone forced the release
                    timeout_d = hold_expired & ~bus.in_done & owner_req;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                // IDLE and GAP both arbitrate; GAP never repeats itself
                if (any_req) begin
                    state_d   = ST_GRANT;
                    address_d = winner;
                    grant_d   = NUM_OUTPUT'(1) << winner;
                    valid_d   = 1'b1;
                    last_d    = winner;
                    hold_d    = '0;
                end else begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    grant_d = '0;
                end
            end
        endcase
    end

    // State and output registers; reset cancels any pending pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            address_q <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            error_q   <= 1'b0;
            hold_q    <= '0;
            last_q    <= LAST_RST;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            error_q   <= error_d;
            hold_q    <= hold_d;
            last_q    <= last_d;
        end
    end

    assign bus.out_address = address_q;
    assign bus.out_grant   = grant_q;
    assign bus.out_valid   = valid_q;
    assign bus.out_timeout = timeout_q;
    assign bus.out_error   = error_q;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// tb/tb_rr_select_arbiter.sv - directed self-checking bench for rr_select_arbiter
module tb_rr_select_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    rr_select_arbiter_if #(.NUM_OUTPUT(4)) bus ();

    rr_select_arbiter #(
        .NUM_OUTPUT (4),
        .MAX_HOLD   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [1:0] a,
                              input logic [3:0] g, input logic t, input logic e);
        chk({tag, ".valid"},   32'(bus.out_valid),   32'(v));
        chk({tag, ".address"}, 32'(bus.out_address), 32'(a));
        chk({tag, ".grant"},   32'(bus.out_grant),   32'(g));
        chk({tag, ".timeout"}, 32'(bus.out_timeout), 32'(t));
        chk({tag, ".error"},   32'(bus.out_error),   32'(e));
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus.in_request = 4'b1111;
        bus.in_done    = 1'b0;

        // 1. reset held two cycles with all requesting
        tick(); expect_out("rst1", 0, 0, 4'b0000, 0, 0);
        tick(); expect_out("rst2", 0, 0, 4'b0000, 0, 0);
        rst = 1'b0;
        tick(); expect_out("first", 1, 0, 4'b0001, 0, 0);
        bus.in_request = 4'b0000;
        tick(); expect_out("first_rel", 0, 0, 4'b0000, 0, 0);
        tick(); expect_out("idle0", 0, 0, 4'b0000, 0, 0);

        // 2. single requester 2, done in third grant cycle
        bus.in_request = 4'b0100;
        tick(); expect_out("single_t1", 1, 2, 4'b0100, 0, 0);
        tick(); expect_out("single_t2", 1, 2, 4'b0100, 0, 0);
        tick(); expect_out("single_t3", 1, 2, 4'b0100, 0, 0);
        bus.in_done = 1'b1;
        tick(); expect_out("single_gap", 0, 2, 4'b0000, 0, 0);
        bus.in_done = 1'b0;
        tick(); expect_out("single_regrant", 1, 2, 4'b0100, 0, 0);
        bus.in_request = 4'b0000;
        tick(); expect_out("single_rel", 0, 2, 4'b0000, 0, 0);
        tick();

        // 3. reset restores requester 0 priority, then full rotation
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_request = 4'b1111;
        tick(); expect_out("rr_g0", 1, 0, 4'b0001, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            logic [1:0] a;
            a = 2'(k);
            bus.in_done = 1'b1;
            tick(); expect_out($sformatf("rr_gap%0d", k), 0, 2'(k - 1), 4'b0000, 0, 0);
            bus.in_done = 1'b0;
            tick(); expect_out($sformatf("rr_g%0d", k), 1, a, 4'b0001 << a, 0, 0);
        end
        bus.in_done = 1'b1;
        tick();
        bus.in_done    = 1'b0;
        bus.in_request = 4'b0000;
        tick(); expect_out("rr_idle", 0, 0, 4'b0000, 0, 0);

        // 4. hold limit of 4 cycles then timeout gap
        bus.in_request = 4'b0010;
        for (int c = 1; c <= 4; c++) begin
            tick(); expect_out($sformatf("to_hold%0d", c), 1, 1, 4'b0010, 0, 0);
        end
        tick(); expect_out("to_gap", 0, 1, 4'b0000, 1, 0);
        tick(); expect_out("to_regrant", 1, 1, 4'b0010, 0, 0);
        tick(); tick(); tick();
        chk("to_4th_valid", 32'(bus.out_valid), 32'd1);
        bus.in_done = 1'b1;
        tick(); expect_out("to_done_gap", 0, 1, 4'b0000, 0, 0);
        bus.in_done    = 1'b0;
        bus.in_request = 4'b0000;
        tick(); expect_out("to_idle", 0, 1, 4'b0000, 0, 0);

        // 5. stray done while idle, then owner drops request
        bus.in_done = 1'b1;
        tick(); expect_out("err_pulse", 0, 1, 4'b0000, 0, 1);
        bus.in_done = 1'b0;
        tick(); expect_out("err_clear", 0, 1, 4'b0000, 0, 0);
        bus.in_request = 4'b1000;
        tick(); expect_out("drop_g", 1, 3, 4'b1000, 0, 0);
        tick();
        bus.in_request = 4'b0000;
        tick(); expect_out("drop_gap", 0, 3, 4'b0000, 0, 0);

        // 6. reset while requester 3 owns the grant
        bus.in_request = 4'b1000;
        tick(); expect_out("mid_g3", 1, 3, 4'b1000, 0, 0);
        rst = 1'b1;
        tick(); expect_out("mid_rst", 0, 0, 4'b0000, 0, 0);
        rst = 1'b0;
        bus.in_request = 4'b1111;
        tick(); expect_out("mid_after", 1, 0, 4'b0001, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
